apb_master_nslv: RTL and testbench
==================================

// Module: apb_master_nslv
// PURPOSE
//  Parametrised APB3 bridge between the RV32I core data port and NUM_SLV peripherals (RAM, GPO, GPI, GPIO, FND, ...).
//  Replaces the fixed six-slave master: slot count and address map are parameters; adds PREADY timeout and decode-error reporting.
//  Sits between RV32I_Core (dataAddr/dataWData/dataWe) and the peripheral PSEL/PRDATA/PREADY fan-in in the MCU top.
// PARAMETERS
//  NUM_SLV    8             number of APB slave slots (1..16)
//  ADDR_W     32            PADDR / addr width
//  DATA_W     32            PWDATA / PRDATA width
//  BASE_ADDR  32'h1000_0000 address of slot 0
//  SLOT_SIZE  32'h0000_1000 bytes per slot, power of two
//  TIMEOUT    16            max ACCESS cycles waiting for PREADY (>=1)
// PORTS
//  PCLK      in   1                 clock, rising edge
//  PRESET    in   1                 synchronous, active-low reset
//  transfer  in   1                 request strobe from core, one cycle
//  write     in   1                 1 = write, 0 = read
//  addr      in   ADDR_W            request address
//  wdata     in   DATA_W            write data
//  rdata     out  DATA_W            read data, valid while ready=1
//  ready     out  1                 transfer complete (one-cycle pulse)
//  error     out  1                 qualifies ready: decode miss or timeout
//  PADDR     out  ADDR_W            APB address (registered)
//  PWDATA    out  DATA_W            APB write data (registered)
//  PWRITE    out  1                 APB direction (registered)
//  PENABLE   out  1                 APB access phase
//  PSEL      out  NUM_SLV           one-hot slave select
//  PRDATA    in   NUM_SLV*DATA_W    slot i at [i*DATA_W +: DATA_W]
//  PREADY    in   NUM_SLV           per-slot ready
// BEHAVIOUR
//  - Reset (PRESET=0 at edge): state IDLE; PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0; ready=0, error=0, rdata=0.
//  - Decode: hit iff addr>=BASE_ADDR and slot=(addr-BASE_ADDR)>>log2(SLOT_SIZE) < NUM_SLV.
//  - FSM IDLE/SETUP/ACCESS/DERR:
//    IDLE: transfer=1 latches addr/wdata/write into PADDR/PWDATA/PWRITE and slot; hit -> SETUP, miss -> DERR.
//    SETUP: PSEL[slot]=1, PENABLE=0; -> ACCESS unconditionally.
//    ACCESS: PSEL[slot]=1, PENABLE=1; PREADY[slot]=1 -> ready=1, rdata=PRDATA[slot] (combinational), -> IDLE.
//    DERR: no PSEL; ready=1, error=1, rdata=0; -> IDLE.
//  - Minimum latency: transfer at cycle N -> SETUP N+1 -> ready in N+2 (zero-wait slave). Decode miss: ready at N+1.
//  - Timeout: wait counter clears on SETUP, increments each ACCESS cycle with PREADY[slot]=0; at count==TIMEOUT-1 with PREADY low
//    the cycle completes with ready=1, error=1, rdata=0; PSEL/PENABLE drop next cycle. PREADY high on that same cycle wins (no error).
//  - transfer while not IDLE is ignored (core must hold off until ready); transfer in the cycle ready=1 is also ignored.
//  - PREADY of unselected slots is don't-care; rdata=0 whenever ready=0.
//  - Reset mid-transfer: bus returns to idle next edge, no ready pulse issued.
//  - Addresses in a slot pass through unmodified on PADDR (slave decodes low bits).
// STRUCTURE
//  - apb_pkg: state enum (IDLE,SETUP,ACCESS,DERR), default BASE_ADDR/SLOT_SIZE constants, slot index width function.
//  - Sub-module apb_addr_decoder: combinational addr -> {hit, slot, one-hot sel}; FSM, counter and mux stay in top.
// TESTING
//  - Write 0x1000_2004 <= 0xDEAD_BEEF, slot 2 PREADY tied 1 -> PSEL=8'b0000_0100 two cycles, PENABLE cycle 2, ready at N+2, error=0.
//  - Read 0x1000_5000, slot 5 PREADY low 3 ACCESS cycles, PRDATA5=0x0000_00A5 -> ready at N+5, rdata=0xA5.
//  - Read 0x1000_9000 (slot 9 >= NUM_SLV) and 0x0FFF_FFFC -> no PSEL, ready+error at N+1, rdata=0.
//  - Slot 1 PREADY stuck 0, TIMEOUT=16 -> ready+error on 16th ACCESS cycle, PSEL=0 next cycle.
//  - PRESET=0 during ACCESS -> all APB outputs 0 next edge, no ready; subsequent write completes normally.
//  - Back-to-back: transfer pulsed while busy and on ready cycle -> ignored; re-issued in IDLE accepted.

Source files
------------

// File: rtl/apb_master_nslv_pkg.sv
// Shared types and constants for the N-slave APB3 master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_master_nslv_pkg;

   // Bus-side state of the master
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DERR   = 2'd3
   } apb_state_t;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
   localparam logic [31:0] DEF_SLOT_SIZE = 32'h0000_1000;

   // Width of a slot index; a single-slot bridge still carries one bit
   function automatic int slot_idx_w(input int num_slv);
      return (num_slv > 1) ? $clog2(num_slv) : 1;
   endfunction

endpackage

// File: rtl/apb_master_nslv_if.sv
// Core-request and APB bus signal bundle for apb_master_nslv.
// Latency: n/a (wiring only).
// Backpressure: core holds off new transfers until ready pulses.
interface apb_master_nslv_if #(
   parameter int NUM_SLV = 8,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
);
   // core request side
   logic                      transfer;
   logic                      write;
   logic [ADDR_W-1:0]         addr;
   logic [DATA_W-1:0]         wdata;
   logic [DATA_W-1:0]         rdata;
   logic                      ready;
   logic                      error;
   // APB side
   logic [ADDR_W-1:0]         PADDR;
   logic [DATA_W-1:0]         PWDATA;
   logic                      PWRITE;
   logic                      PENABLE;
   logic [NUM_SLV-1:0]        PSEL;
   logic [NUM_SLV*DATA_W-1:0] PRDATA;
   logic [NUM_SLV-1:0]        PREADY;

   modport master (
      input  transfer, write, addr, wdata, PRDATA, PREADY,
      output rdata, ready, error, PADDR, PWDATA, PWRITE, PENABLE, PSEL
   );

   modport slave (
      output transfer, write, addr, wdata, PRDATA, PREADY,
      input  rdata, ready, error, PADDR, PWDATA, PWRITE, PENABLE, PSEL
   );

endinterface

// File: rtl/apb_master_nslv_addr_decoder.sv
// Address decoder: maps a request address onto a slave slot (hit, index, one-hot select).
// Latency: purely combinational.
// Backpressure: none.
module apb_master_nslv_addr_decoder
   import apb_master_nslv_pkg::*;
#(
   parameter int                NUM_SLV   = 8,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
   parameter logic [ADDR_W-1:0] SLOT_SIZE = ADDR_W'(DEF_SLOT_SIZE),
   localparam int               SLOT_W    = slot_idx_w(NUM_SLV)
) (
   input  logic [ADDR_W-1:0]  addr,
   output logic               hit,
   output logic [SLOT_W-1:0]  slot,
   output logic [NUM_SLV-1:0] sel
);

   localparam int SLOT_SH = $clog2(SLOT_SIZE);

   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] idx;

   // Slot index is the offset from the base divided by the (power-of-two) slot size
   always_comb begin
      offset = addr - BASE_ADDR;
      idx    = offset >> SLOT_SH;
      hit    = (addr >= BASE_ADDR) && (idx < ADDR_W'(NUM_SLV));
      slot   = idx[SLOT_W-1:0];
      sel    = '0;
      if (hit) begin
         sel[slot] = 1'b1;
      end
   end

endmodule

// File: rtl/apb_master_nslv.sv
// APB3 master bridging the core data port to NUM_SLV slaves, with decode-error and PREADY timeout.
// Latency: ready two cycles after transfer for a zero-wait slave, one cycle for a decode miss.
// Backpressure: slave PREADY stretches ACCESS up to TIMEOUT cycles; transfers outside IDLE are dropped.
module apb_master_nslv
   import apb_master_nslv_pkg::*;
#(
   parameter int                NUM_SLV   = 8,
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
   parameter logic [ADDR_W-1:0] SLOT_SIZE = ADDR_W'(DEF_SLOT_SIZE),
   parameter int                TIMEOUT   = 16
) (
   input logic                PCLK,
   input logic                PRESET,
   apb_master_nslv_if.master  bus
);

   localparam int SLOT_W = slot_idx_w(NUM_SLV);
   localparam int CNT_W  = $clog2(TIMEOUT + 1);

   apb_state_t         state_q, state_d;
   logic [ADDR_W-1:0]  paddr_q, paddr_d;
   logic [DATA_W-1:0]  pwdata_q, pwdata_d;
   logic               pwrite_q, pwrite_d;
   logic [SLOT_W-1:0]  slot_q, slot_d;
   logic [NUM_SLV-1:0] sel_q, sel_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               dec_hit;
   logic [SLOT_W-1:0]  dec_slot;
   logic [NUM_SLV-1:0] dec_sel;

   logic [NUM_SLV-1:0] psel_c;
   logic               penable_c;
   logic               ready_c;
   logic               error_c;
   logic [DATA_W-1:0]  rdata_c;

   apb_master_nslv_addr_decoder #(
      .NUM_SLV   (NUM_SLV),
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR),
      .SLOT_SIZE (SLOT_SIZE)
   ) u_dec (
      .addr (bus.addr),
      .hit  (dec_hit),
      .slot (dec_slot),
      .sel  (dec_sel)
   );

   // State and latched request registers; reset returns the bus to idle with no ready pulse
   always_ff @(posedge PCLK) begin
      if (!PRESET) begin
         state_q  <= IDLE;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
         slot_q   <= '0;
         sel_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         pwrite_q <= pwrite_d;
         slot_q   <= slot_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next state, wait counter and completion/read-data mux
   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pwrite_d  = pwrite_q;
      slot_d    = slot_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      psel_c    = '0;
      penable_c = 1'b0;
      ready_c   = 1'b0;
      error_c   = 1'b0;
      rdata_c   = '0;
      case (state_q)
         IDLE: begin
            if (bus.transfer) begin
               paddr_d  = bus.addr;
               pwdata_d = bus.wdata;
               pwrite_d = bus.write;
               slot_d   = dec_slot;
               sel_d    = dec_sel;
               state_d  = dec_hit ? SETUP : DERR;
            end
         end
         SETUP: begin
            psel_c  = sel_q;
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            psel_c    = sel_q;
            penable_c = 1'b1;
            // A slave answering on the timeout cycle still completes cleanly
            if (bus.PREADY[slot_q]) begin
               ready_c = 1'b1;
               rdata_c = bus.PRDATA[slot_q*DATA_W +: DATA_W];
               state_d = IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               ready_c = 1'b1;
               error_c = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DERR: begin
            ready_c = 1'b1;
            error_c = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.PADDR   = paddr_q;
   assign bus.PWDATA  = pwdata_q;
   assign bus.PWRITE  = pwrite_q;
   assign bus.PSEL    = psel_c;
   assign bus.PENABLE = penable_c;
   assign bus.ready   = ready_c;
   assign bus.error   = error_c;
   assign bus.rdata   = rdata_c;

endmodule

// File: tb/tb_apb_master_nslv.sv
// Randomised bench for apb_master_nslv against a transaction-level reference model.
// Latency: n/a.
// Backpressure: bench drives PREADY per slot with a chosen wait count.
module tb_apb_master_nslv;
   import apb_master_nslv_pkg::*;

   localparam int          NUM_SLV = 8;
   localparam int          ADDR_W  = 32;
   localparam int          DATA_W  = 32;
   localparam int          TIMEOUT = 16;
   localparam logic [31:0] BASE    = 32'h1000_0000;
   localparam logic [31:0] SSIZE   = 32'h0000_1000;

   logic PCLK = 1'b0;
   logic PRESET;
   int   n_chk = 0;
   int   n_err = 0;

   logic [DATA_W-1:0] prd [NUM_SLV];

   apb_master_nslv_if #(.NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_master_nslv #(
      .NUM_SLV   (NUM_SLV),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BASE_ADDR (BASE),
      .SLOT_SIZE (SSIZE),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .bus    (bus)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_prdata();
      for (int i = 0; i < NUM_SLV; i++) begin
         bus.PRDATA[i*DATA_W +: DATA_W] = prd[i];
      end
   endtask

   // Reference decode: plain division of the offset by the slot size
   task automatic ref_decode(input logic [31:0] a, output bit hit, output int slot);
      longint unsigned idx;
      hit  = 1'b0;
      slot = 0;
      if (a >= BASE) begin
         idx = longint'(a - BASE) / longint'(SSIZE);
         if (idx < NUM_SLV) begin
            hit  = 1'b1;
            slot = int'(idx);
         end
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "/psel"},    bus.PSEL,    '0);
      chk({tag, "/penable"}, bus.PENABLE, 0);
      chk({tag, "/ready"},   bus.ready,   0);
      chk({tag, "/error"},   bus.error,   0);
      chk({tag, "/rdata"},   bus.rdata,   0);
   endtask

   // One transaction; waitc = ACCESS cycles the selected slave holds PREADY low
   task automatic do_txn(input string tag, input logic [31:0] a, input bit wr,
                         input logic [31:0] wd, input int waitc,
                         input logic [31:0] rd, input bit spur);
      bit                 hit;
      int                 slot;
      int                 lat;
      bit                 exp_err;
      logic [31:0]        exp_rd;
      logic [NUM_SLV-1:0] exp_sel;
      bit                 last;
      ref_decode(a, hit, slot);
      for (int i = 0; i < NUM_SLV; i++) prd[i] = $urandom;
      if (hit) prd[slot] = rd;
      if (!hit) begin
         lat = 1; exp_err = 1'b1;
      end else if (waitc < TIMEOUT) begin
         lat = 2 + waitc; exp_err = 1'b0;
      end else begin
         lat = 1 + TIMEOUT; exp_err = 1'b1;
      end
      exp_rd  = exp_err ? 32'h0 : rd;
      exp_sel = hit ? (NUM_SLV'(1) << slot) : '0;

      @(negedge PCLK);
      set_prdata();
      bus.transfer = 1'b1;
      bus.write    = wr;
      bus.addr     = a;
      bus.wdata    = wd;
      bus.PREADY   = NUM_SLV'($urandom);
      #1;
      chk_idle({tag, "/req"});

      for (int k = 1; k <= lat; k++) begin
         @(negedge PCLK);
         bus.transfer = spur;
         bus.addr     = BASE + ($urandom_range(0, 9 * 32'h1000 - 1) & 32'hFFFF_FFFC);
         bus.write    = 1'($urandom);
         bus.wdata    = $urandom;
         bus.PREADY   = NUM_SLV'($urandom);
         if (hit && k >= 2) bus.PREADY[slot] = ((k - 2) >= waitc);
         #1;
         last = (k == lat);
         chk({tag, "/psel"},    bus.PSEL,    exp_sel);
         chk({tag, "/penable"}, bus.PENABLE, hit && k >= 2);
         chk({tag, "/ready"},   bus.ready,   last);
         chk({tag, "/error"},   bus.error,   last && exp_err);
         chk({tag, "/rdata"},   bus.rdata,   last ? exp_rd : 32'h0);
         chk({tag, "/paddr"},   bus.PADDR,   a);
         chk({tag, "/pwrite"},  bus.PWRITE,  wr);
         chk({tag, "/pwdata"},  bus.PWDATA,  wd);
      end

      @(negedge PCLK);
      bus.transfer = 1'b0;
      bus.PREADY   = NUM_SLV'($urandom);
      #1;
      chk_idle({tag, "/after"});
      chk({tag, "/after_paddr"}, bus.PADDR, a);
   endtask

   initial begin
      logic [31:0] a;
      int          cat;
      int          r;
      int          waitc;

      PRESET       = 1'b0;
      bus.transfer = 1'b0;
      bus.write    = 1'b0;
      bus.addr     = '0;
      bus.wdata    = '0;
      bus.PREADY   = '0;
      bus.PRDATA   = '0;
      repeat (3) @(negedge PCLK);
      #1;
      chk_idle("reset");
      chk("reset/paddr",  bus.PADDR,  0);
      chk("reset/pwdata", bus.PWDATA, 0);
      chk("reset/pwrite", bus.PWRITE, 0);
      PRESET = 1'b1;

      // directed scenarios
      do_txn("wr_slot2",   32'h1000_2004, 1'b1, 32'hDEAD_BEEF, 0, $urandom, 1'b0);
      do_txn("rd_slot5",   32'h1000_5000, 1'b0, 32'h0, 3, 32'h0000_00A5, 1'b0);
      do_txn("miss_hi",    32'h1000_9000, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b0);
      do_txn("miss_lo",    32'h0FFF_FFFC, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b0);
      do_txn("last_slot",  32'h1000_7FFC, 1'b0, 32'h0, 1, 32'hCAFE_0007, 1'b0);
      do_txn("past_last",  32'h1000_8000, 1'b1, 32'h5555_AAAA, 0, 32'h0, 1'b0);
      do_txn("timeout",    32'h1000_1000, 1'b0, 32'h0, 1000, 32'h1111_1111, 1'b0);
      do_txn("late_rdy",   32'h1000_3008, 1'b0, 32'h0, TIMEOUT - 1, 32'h3333_0008, 1'b0);
      do_txn("tmo_edge",   32'h1000_4000, 1'b1, 32'h4444_4444, TIMEOUT, 32'h0, 1'b0);

      // reset while in ACCESS with the slave stalling
      @(negedge PCLK);
      bus.transfer = 1'b1; bus.write = 1'b0; bus.addr = 32'h1000_3000; bus.PREADY = '0;
      @(negedge PCLK);
      bus.transfer = 1'b0;
      @(negedge PCLK);
      #1;
      chk("rst_mid/penable_before", bus.PENABLE, 1);
      PRESET = 1'b0;
      @(negedge PCLK);
      PRESET = 1'b1;
      #1;
      chk_idle("rst_mid");
      chk("rst_mid/paddr",  bus.PADDR,  0);
      chk("rst_mid/pwdata", bus.PWDATA, 0);
      chk("rst_mid/pwrite", bus.PWRITE, 0);
      do_txn("post_rst_wr", 32'h1000_6010, 1'b1, 32'h0BAD_F00D, 0, 32'h0, 1'b0);

      // transfers while busy / on the ready cycle, then a re-issue in IDLE
      do_txn("spur_busy",  32'h1000_2000, 1'b0, 32'h0, 2, 32'h2222_0000, 1'b1);
      do_txn("spur_miss",  32'h2000_0000, 1'b0, 32'h0, 0, 32'h0, 1'b1);
      do_txn("reissue",    32'h1000_2000, 1'b0, 32'h0, 0, 32'h2222_0001, 1'b0);

      // randomised traffic
      for (int t = 0; t < 150; t++) begin
         cat = $urandom_range(0, 9);
         if (cat <= 6) begin
            a = BASE + $urandom_range(0, NUM_SLV - 1) * SSIZE + ($urandom_range(0, 1023) << 2);
         end else if (cat == 7) begin
            a = BASE + $urandom_range(NUM_SLV, 16'hFFFF) * SSIZE + ($urandom_range(0, 1023) << 2);
         end else if (cat == 8) begin
            a = $urandom_range(0, 32'h0FFF_FFFF);
         end else begin
            a = $urandom;
         end
         r = $urandom_range(0, 9);
         if (r < 7)       waitc = $urandom_range(0, 3);
         else if (r == 7) waitc = TIMEOUT - 1;
         else if (r == 8) waitc = TIMEOUT;
         else             waitc = $urandom_range(TIMEOUT + 1, TIMEOUT + 14);
         do_txn("rand", a, 1'($urandom), $urandom, waitc, $urandom, 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
